// File: rtl/pipe_stage_buf.sv
// Handshaked pipeline stage register with optional skid entry,
// synchronous flush and a sticky halt tracker.
module pipe_stage_buf #(
    parameter int WIDTH = 32,
    parameter int SKID  = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_halt,
    input  logic             flush,
    output logic             halted,
    output logic [1:0]       count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] skid_data;
    logic             skid_halt;
    logic             push;
    logic             pop;
    logic             fill_skid;

    // state encoding doubles as the occupancy count
    assign count     = state;
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign fill_skid = push & ~pop & (state != EMPTY);

    // skid mode: ready is registered-only; single mode: ready follows out_ready
    always_comb begin
        if (SKID != 0)
            in_ready = (state != TWO) & ~halted;
        else
            in_ready = ((state == EMPTY) | out_ready) & ~halted;
    end

    // occupancy and head entry; flush discards any same-cycle transfer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= EMPTY;
            out_data <= '0;
            out_halt <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            unique case (1'b1)
                push & pop: begin
                    out_data <= in_data;
                    out_halt <= in_halt;
                end
                push & ~pop & (state == EMPTY): begin
                    state    <= ONE;
                    out_data <= in_data;
                    out_halt <= in_halt;
                end
                push & ~pop & (state != EMPTY): begin
                    state <= TWO;
                end
                ~push & pop & (state == TWO): begin
                    state    <= ONE;
                    out_data <= skid_data;
                    out_halt <= skid_halt;
                end
                ~push & pop & (state != TWO): begin
                    state <= EMPTY;
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    // second entry captures a push that arrives while the head is stalled
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            skid_data <= '0;
            skid_halt <= 1'b0;
        end else if (!flush && fill_skid) begin
            skid_data <= in_data;
            skid_halt <= in_halt;
        end
    end

    // halted latches once a halt entry actually leaves downstream
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            halted <= 1'b0;
        else if (!flush && pop && out_halt)
            halted <= 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Random scoreboard bench for pipe_stage_buf.
// Lane 0 runs SKID=1, lane 1 runs SKID=0.
module tb_pipe_stage_buf;

    logic        CLK;
    logic [1:0]  nRST;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [31:0] in_data [2];
    logic [1:0]  in_halt;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [31:0] out_data [2];
    logic [1:0]  out_halt;
    logic [1:0]  flush;
    logic [1:0]  halted;
    logic [1:0]  count [2];
    logic [1:0]  done;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int G = g;

        logic [32:0] sb [$];
        logic        exp_halted;
        logic        exp_rdy;
        logic        running;
        logic [32:0] e;

        pipe_stage_buf #(
            .WIDTH(32),
            .SKID (g == 0 ? 1 : 0)
        ) dut (
            .CLK      (CLK),
            .nRST     (nRST[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .in_halt  (in_halt[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .out_halt (out_halt[g]),
            .flush    (flush[g]),
            .halted   (halted[g]),
            .count    (count[g])
        );

        // monitor: status against the model, then pop and compare
        initial begin
            exp_rdy = 1'b0;
            forever begin
                @(negedge CLK);
                #1;
                if (running) begin
                    if (G == 0)
                        exp_rdy = !exp_halted && (sb.size() < 2);
                    else
                        exp_rdy = !exp_halted &&
                                  (sb.size() == 0 || out_ready[G]);
                    chk($sformatf("lane%0d count", G),
                        64'(count[G]), 64'(sb.size()));
                    chk($sformatf("lane%0d out_valid", G),
                        64'(out_valid[G]), 64'(sb.size() != 0));
                    chk($sformatf("lane%0d in_ready", G),
                        64'(in_ready[G]), 64'(exp_rdy));
                    chk($sformatf("lane%0d halted", G),
                        64'(halted[G]), 64'(exp_halted));
                    if (out_valid[G] && out_ready[G] && !flush[G]) begin
                        if (sb.size() == 0) begin
                            chk($sformatf("lane%0d spurious pop", G),
                                64'(out_valid[G]), 64'(0));
                        end else begin
                            e = sb.pop_front();
                            chk($sformatf("lane%0d out_data", G),
                                64'(out_data[G]), 64'(e[31:0]));
                            chk($sformatf("lane%0d out_halt", G),
                                64'(out_halt[G]), 64'(e[32]));
                            if (e[32])
                                exp_halted = 1'b1;
                        end
                    end
                end
            end
        end

        // driver: random stimulus, expected entries pushed on acceptance
        initial begin
            running        = 1'b0;
            exp_halted     = 1'b0;
            done[G]        = 1'b0;
            nRST[G]        = 1'b0;
            in_valid[G]    = 1'b0;
            in_halt[G]     = 1'b0;
            in_data[G]     = '0;
            out_ready[G]   = 1'b0;
            flush[G]       = 1'b0;
            for (int ep = 0; ep < 8; ep++) begin
                @(negedge CLK);
                running = 1'b0;
                nRST[G] = 1'b0;
                #1;
                chk($sformatf("lane%0d rst count", G), 64'(count[G]), 64'(0));
                chk($sformatf("lane%0d rst out_valid", G),
                    64'(out_valid[G]), 64'(0));
                chk($sformatf("lane%0d rst out_data", G),
                    64'(out_data[G]), 64'(0));
                chk($sformatf("lane%0d rst out_halt", G),
                    64'(out_halt[G]), 64'(0));
                chk($sformatf("lane%0d rst halted", G),
                    64'(halted[G]), 64'(0));
                chk($sformatf("lane%0d rst in_ready", G),
                    64'(in_ready[G]), 64'(1));
                in_valid[G]  = 1'b0;
                out_ready[G] = 1'b0;
                flush[G]     = 1'b0;
                in_halt[G]   = 1'b0;
                #1;
                nRST[G]    = 1'b1;
                sb.delete();
                exp_halted = 1'b0;
                running    = 1'b1;
                repeat (200) begin
                    @(negedge CLK);
                    in_valid[G]  = ($urandom_range(0, 9) < 7);
                    in_data[G]   = $urandom;
                    in_halt[G]   = (ep % 2 == 1) &&
                                   ($urandom_range(0, 39) == 0);
                    out_ready[G] = ($urandom_range(0, 9) <
                                    ((ep % 3 == 0) ? 2 : 6));
                    flush[G]     = ($urandom_range(0, 29) == 0);
                    #2;
                    if (flush[G])
                        sb.delete();
                    else if (in_valid[G] && exp_rdy)
                        sb.push_back({in_halt[G], in_data[G]});
                end
            end
            @(negedge CLK);
            running = 1'b0;
            done[G] = 1'b1;
        end
    end

    initial begin
        wait (done == 2'b11);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
